key_delay_module: RTL and testbench

- Downstream stage of the key edge detector.
- Consumes its single-cycle H2L_Sig/L2H_Sig pulses and requires the new level to hold for DELAY_MS milliseconds before committing it.
- Outputs a debounced key level plus one-cycle press/release strobes to the GPIO/PWM control logic.
- Key is active-low: idle = 1, pressed = 0.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_delay_module_if.sv | 28 ++
 rtl/key_delay_module_ms_tick_gen.sv | 45 ++++
 rtl/key_delay_module.sv | 108 ++++++++++
 tb/tb_key_delay_module.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debounce stage: FSM state encodings and
// default timing constants for a 50 MHz system clock.
package key_pkg;

    typedef enum logic [1:0] {
        S_HIGH      = 2'd0,
        S_WAIT_LOW  = 2'd1,
        S_LOW       = 2'd2,
        S_WAIT_HIGH = 2'd3
    } key_state_e;

    localparam logic [15:0] T1MS_50M     = 16'd49_999;
    localparam logic [7:0]  DELAY_MS_DEF = 8'd10;

    function automatic logic is_wait_state(input key_state_e st);
        return (st == S_WAIT_LOW) || (st == S_WAIT_HIGH);
    endfunction

endpackage

// File: rtl/key_delay_module_if.sv
// Edge-pulse inputs from the edge detector and the debounced level/strobe
// outputs towards the GPIO/PWM control logic.
interface key_delay_if;

    logic H2L_Sig;
    logic L2H_Sig;
    logic Key_Level;
    logic Press_Pulse;
    logic Release_Pulse;

    // Master: the side that produces edge pulses and consumes the debounced key.
    modport master (
        output H2L_Sig,
        output L2H_Sig,
        input  Key_Level,
        input  Press_Pulse,
        input  Release_Pulse
    );

    modport slave (
        input  H2L_Sig,
        input  L2H_Sig,
        output Key_Level,
        output Press_Pulse,
        output Release_Pulse
    );

endinterface

// File: rtl/key_delay_module_ms_tick_gen.sv
// Millisecond window timer: a prescaler wrapping at T1MS drives a ms counter;
// done_o flags the last cycle of a DELAY_MS-long window.
module ms_tick_gen #(
    parameter logic [15:0] T1MS     = 16'd49_999,
    parameter logic [7:0]  DELAY_MS = 8'd10
) (
    input  logic CLOCK,
    input  logic RST_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  ms_q,    ms_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        presc_d = presc_q;
        ms_d    = ms_q;
        if (clear_i || !enable_i) begin
            presc_d = 16'd0;
            ms_d    = 8'd0;
        end else if (presc_q == T1MS) begin
            presc_d = 16'd0;
            ms_d    = ms_q + 8'd1;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            presc_q <= 16'd0;
            ms_q    <= 8'd0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
            presc_q <= presc_d;
            ms_q    <= ms_d;
        end
    end

    assign done_o = enable_i && (presc_q == T1MS) && (ms_q == DELAY_MS - 8'd1);

endmodule

// File: rtl/key_delay_module.sv
// Debounce stage: a level change is committed only after the opposite edge has
// been followed by DELAY_MS ms of quiet; commits emit a one-cycle strobe.
module key_delay_module
    import key_pkg::*;
#(
    parameter logic [15:0] T1MS     = T1MS_50M,
    parameter logic [7:0]  DELAY_MS = DELAY_MS_DEF
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    key_delay_if.slave        bus
);

    key_state_e state_q, state_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;
    logic       tick_clear;
    logic       tick_enable;
    logic       done;
    logic       edge_h2l;
    logic       edge_l2h;

    // Both pulses together is an upstream fault and is treated as no edge.
    assign edge_h2l = bus.H2L_Sig & ~bus.L2H_Sig;
    assign edge_l2h = bus.L2H_Sig & ~bus.H2L_Sig;

    assign tick_enable = is_wait_state(state_q);

    ms_tick_gen #(
        .T1MS     (T1MS),
        .DELAY_MS (DELAY_MS)
    ) u_tick (
        .CLOCK    (CLOCK),
        .RST_n    (RST_n),
        .clear_i  (tick_clear),
        .enable_i (tick_enable),
        .done_o   (done)
    );

    // Edges are tested before done, so an edge on the timeout cycle wins.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        tick_clear = 1'b0;
        unique case (state_q)
            S_HIGH: begin
                tick_clear = 1'b1;
                if (edge_h2l) state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (edge_l2h) begin
                    state_d    = S_HIGH;
                    tick_clear = 1'b1;
                end else if (edge_h2l) begin
                    tick_clear = 1'b1;
                end else if (done) begin
                    state_d    = S_LOW;
                    level_d    = 1'b0;
                    press_d    = 1'b1;
                    tick_clear = 1'b1;
                end
            end
            S_LOW: begin
                tick_clear = 1'b1;
                if (edge_l2h) state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (edge_h2l) begin
                    state_d    = S_LOW;
                    tick_clear = 1'b1;
                end else if (edge_l2h) begin
                    tick_clear = 1'b1;
                end else if (done) begin
                    state_d    = S_HIGH;
                    level_d    = 1'b1;
                    release_d  = 1'b1;
                    tick_clear = 1'b1;
                end
            end
            default: begin
                state_d    = S_HIGH;
                tick_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_HIGH;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign bus.Key_Level     = level_q;
    assign bus.Press_Pulse   = press_q;
    assign bus.Release_Pulse = release_q;

endmodule

// File: tb/tb_key_delay_module.sv
// Directed bench for key_delay_module with T1MS=9, DELAY_MS=3 (30-cycle window),
// checked every cycle against a deadline-based model plus pinned literals.
module tb_key_delay_module;
    import key_pkg::*;

    localparam logic [15:0] TB_T1MS  = 16'd9;
    localparam logic [7:0]  TB_DELAY = 8'd3;
    localparam int          N        = 30;
    localparam int          N_CYC    = 150;
    localparam int          N_SCEN   = 7;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Model: committed level, whether a change is pending, and its deadline cycle.
    logic m_level;
    logic m_pend;
    int   m_dl;
    logic m_press;
    logic m_rel;

    key_delay_if bus();

    key_delay_module #(
        .T1MS     (TB_T1MS),
        .DELAY_MS (TB_DELAY)
    ) dut (
        .CLOCK (clk),
        .RST_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int s, input int c,
                         input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s scen=%0d cyc=%0d got=%0b expected=%0b", name, s, c, act, exp);
        end
    endtask

    // Returns {rst_n, H2L_Sig, L2H_Sig} to apply for edge c of scenario s.
    function automatic logic [2:0] stim(input int s, input int c);
        logic r, h, l;
        r = 1'b1; h = 1'b0; l = 1'b0;
        case (s)
            1: h = (c == 10);
            2: begin h = (c == 10) || (c == 20); l = (c == 15); end
            3: begin h = (c == 10); l = (c == 25); end
            4: begin h = (c == 10); l = (c == 100); end
            5: begin h = (c == 10); r = !((c == 30) || (c == 31)); end
            6: begin h = (c == 10) || (c == 40) || (c == 50); l = (c == 50); end
            default: ;
        endcase
        return {r, h, l};
    endfunction

    task automatic model_step(input int c, input logic r, input logic h, input logic l);
        logic is_press;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (!r) begin
            m_level = 1'b1;
            m_pend  = 1'b0;
        end else if (h ^ l) begin
            is_press = h;
            // An edge towards the opposite level (re)starts the window; one back towards the level aborts it.
            if (is_press == m_level) begin
                m_pend = 1'b1;
                m_dl   = c + N;
            end else begin
                m_pend = 1'b0;
            end
        end else if (m_pend && c == m_dl) begin
            m_level = ~m_level;
            m_pend  = 1'b0;
            if (m_level) m_rel = 1'b1;
            else         m_press = 1'b1;
        end
    endtask

    task automatic pins(input int s, input int c);
        if (s == 1 && c == 39) check("s1_no_press_39", s, c, bus.Press_Pulse, 1'b0);
        if (s == 1 && c == 40) check("s1_press_40", s, c, bus.Press_Pulse, 1'b1);
        if (s == 1 && c == 40) check("s1_level_40", s, c, bus.Key_Level, 1'b0);
        if (s == 1 && c == 41) check("s1_press_gone_41", s, c, bus.Press_Pulse, 1'b0);
        if (s == 2 && c == 40) check("s2_no_press_40", s, c, bus.Press_Pulse, 1'b0);
        if (s == 2 && c == 50) check("s2_press_50", s, c, bus.Press_Pulse, 1'b1);
        if (s == 3 && c == 26) check("s3_state_high_26", s, c, dut.state_q == S_HIGH, 1'b1);
        if (s == 3 && c == N_CYC) check("s3_level_end", s, c, bus.Key_Level, 1'b1);
        if (s == 4 && c == 129) check("s4_level_129", s, c, bus.Key_Level, 1'b0);
        if (s == 4 && c == 130) check("s4_release_130", s, c, bus.Release_Pulse, 1'b1);
        if (s == 4 && c == 130) check("s4_level_130", s, c, bus.Key_Level, 1'b1);
        if (s == 5 && c == 30) check("s5_level_rst_30", s, c, bus.Key_Level, 1'b1);
        if (s == 5 && c == 40) check("s5_no_press_40", s, c, bus.Press_Pulse, 1'b0);
        if (s == 6 && c == 40) check("s6_edge_wins_40", s, c, bus.Press_Pulse, 1'b0);
        if (s == 6 && c == 70) check("s6_press_70", s, c, bus.Press_Pulse, 1'b1);
    endtask

    initial begin
        logic [2:0] v;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.H2L_Sig = 1'b0;
        bus.L2H_Sig = 1'b0;
        for (int s = 0; s < N_SCEN; s++) begin
            rst_n = 1'b0;
            bus.H2L_Sig = 1'b0;
            bus.L2H_Sig = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("rst_level", s, 0, bus.Key_Level, 1'b1);
            check("rst_press", s, 0, bus.Press_Pulse, 1'b0);
            check("rst_release", s, 0, bus.Release_Pulse, 1'b0);
            m_level = 1'b1;
            m_pend  = 1'b0;
            m_dl    = 0;
            m_press = 1'b0;
            m_rel   = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 1; c <= N_CYC; c++) begin
                @(negedge clk);
                v = stim(s, c);
                rst_n       = v[2];
                bus.H2L_Sig = v[1];
                bus.L2H_Sig = v[0];
                @(posedge clk);
                model_step(c, v[2], v[1], v[0]);
                #1;
                check("level", s, c, bus.Key_Level, m_level);
                check("press", s, c, bus.Press_Pulse, m_press);
                check("release", s, c, bus.Release_Pulse, m_rel);
                pins(s, c);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
